// File: rtl/color_classifier_roi_if.sv
// Bundle of start/busy/done handshake, ROI configuration, frame RAM read port
// and published results for the ROI colour classifier.
interface color_classifier_roi_if #(
   parameter int ADDR_W = 15,
   parameter int ACC_W  = 20
);
   logic              i_start;
   logic [ADDR_W-1:0] i_bytes_per_frame;
   logic [7:0]        i_roi_x0;
   logic [7:0]        i_roi_x1;
   logic [7:0]        i_roi_y0;
   logic [7:0]        i_roi_y1;
   logic [ACC_W-1:0]  i_margin;
   logic [7:0]        i_ram_data;
   logic [ADDR_W-1:0] o_ram_addr;
   logic              o_busy;
   logic              o_done;
   logic [7:0]        o_color;
   logic [ACC_W-1:0]  o_sum_r;
   logic [ACC_W-1:0]  o_sum_g;
   logic [ACC_W-1:0]  o_sum_b;
   logic [ADDR_W-1:0] o_pix_count;

   modport slave (
      input  i_start, i_bytes_per_frame, i_roi_x0, i_roi_x1, i_roi_y0, i_roi_y1,
             i_margin, i_ram_data,
      output o_ram_addr, o_busy, o_done, o_color, o_sum_r, o_sum_g, o_sum_b,
             o_pix_count
   );

   modport master (
      output i_start, i_bytes_per_frame, i_roi_x0, i_roi_x1, i_roi_y0, i_roi_y1,
             i_margin, i_ram_data,
      input  o_ram_addr, o_busy, o_done, o_color, o_sum_r, o_sum_g, o_sum_b,
             o_pix_count
   );
endinterface

// File: rtl/color_classifier_roi.sv
// Reads one frame of 16-bit pixels (two bytes each) from a byte-wide RAM,
// sums R/G/B over a rectangular ROI and classifies the dominant colour.
module color_classifier_roi #(
   parameter int ADDR_W      = 15,
   parameter int ACC_W       = 20,
   parameter int IMG_W       = 160,
   parameter int RAM_LATENCY = 1,
   parameter int FORMAT      = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   color_classifier_roi_if.slave bus
);
   localparam int CW = 16;
   localparam logic [CW-1:0] X_LAST     = CW'(IMG_W - 1);
   localparam logic [1:0]    DRAIN_INIT = 2'(RAM_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DECIDE} state_t;
   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q, last_q, cnt_q, cnt_pub_q, even_len;
   logic [7:0]        x0_q, x1_q, y0_q, y1_q, hi_q, color_q, color_d;
   logic [ACC_W-1:0]  margin_q, acc_r_q, acc_g_q, acc_b_q;
   logic [ACC_W-1:0]  sum_r_q, sum_g_q, sum_b_q, diff1, diff2;
   logic [CW-1:0]     x_q, y_q;
   logic [1:0]        drain_q;
   logic              busy_q, done_q, top;
   logic              accept, fetch, decide, fetch_last, in_roi;
   logic [4:0]        pix_r, pix_g, pix_b;
   logic [RAM_LATENCY:0] vld_w, odd_w;

   assign even_len   = {bus.i_bytes_per_frame[ADDR_W-1:1], 1'b0};
   assign fetch_last = (addr_q == last_q);

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = (even_len == '0) ? S_DRAIN : S_FETCH;
         S_FETCH:  if (fetch_last) state_d = S_DRAIN;
         S_DRAIN:  if (drain_q == 2'd0) state_d = S_DECIDE;
         S_DECIDE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // A start coinciding with the done pulse is deliberately not accepted.
   always_comb begin
      accept = (state_q == S_IDLE) && bus.i_start && !done_q;
      fetch  = (state_q == S_FETCH);
      decide = (state_q == S_DECIDE);
   end

   assign vld_w[0] = fetch;
   assign odd_w[0] = addr_q[0];

   generate
      for (genvar gi = 0; gi < RAM_LATENCY; gi++) begin : g_pipe
         logic vld_q, odd_q;
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               vld_q <= 1'b0;
               odd_q <= 1'b0;
            end else begin
               vld_q <= vld_w[gi];
               odd_q <= odd_w[gi];
            end
         end
         assign vld_w[gi+1] = vld_q;
         assign odd_w[gi+1] = odd_q;
      end

      if (FORMAT == 1) begin : g_rgb565
         assign pix_r = hi_q[7:3];
         assign pix_g = 5'({hi_q[2:0], bus.i_ram_data[7:5]} >> 1);
      end else begin : g_xrgb1555
         // Bit 7 of the high byte is padding and is masked off.
         assign pix_r = 5'((hi_q & 8'h7F) >> 2);
         assign pix_g = {hi_q[1:0], bus.i_ram_data[7:5]};
      end
   endgenerate

   assign pix_b  = bus.i_ram_data[4:0];
   assign in_roi = (x_q >= {8'd0, x0_q}) && (x_q <= {8'd0, x1_q}) &&
                   (y_q >= {8'd0, y0_q}) && (y_q <= {8'd0, y1_q});

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                  input logic [4:0] v);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {{(ACC_W-4){1'b0}}, v};
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction

   always_comb begin
      color_d = 8'h00;
      top     = 1'b0;
      diff1   = '0;
      diff2   = '0;
      if (acc_r_q > acc_g_q && acc_r_q > acc_b_q) begin
         top = 1'b1; color_d = 8'h01;
         diff1 = acc_r_q - acc_g_q; diff2 = acc_r_q - acc_b_q;
      end else if (acc_g_q > acc_r_q && acc_g_q > acc_b_q) begin
         top = 1'b1; color_d = 8'h02;
         diff1 = acc_g_q - acc_r_q; diff2 = acc_g_q - acc_b_q;
      end else if (acc_b_q > acc_r_q && acc_b_q > acc_g_q) begin
         top = 1'b1; color_d = 8'h03;
         diff1 = acc_b_q - acc_r_q; diff2 = acc_b_q - acc_g_q;
      end
      if (top && diff1 < margin_q && diff2 < margin_q) color_d = 8'h04;
   end

   always_ff @(posedge i_clk) begin
      if (state_q != S_DRAIN) drain_q <= DRAIN_INIT;
      else                    drain_q <= drain_q - 2'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr_q    <= '0;  last_q  <= '0;  cnt_q   <= '0;  cnt_pub_q <= '0;
         x0_q      <= '0;  x1_q    <= '0;  y0_q    <= '0;  y1_q      <= '0;
         hi_q      <= '0;  margin_q <= '0; x_q     <= '0;  y_q       <= '0;
         acc_r_q   <= '0;  acc_g_q <= '0;  acc_b_q <= '0;
         sum_r_q   <= '0;  sum_g_q <= '0;  sum_b_q <= '0;
         color_q   <= 8'hF0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (accept) begin
            last_q   <= even_len - ADDR_W'(1);
            x0_q     <= bus.i_roi_x0;  x1_q <= bus.i_roi_x1;
            y0_q     <= bus.i_roi_y0;  y1_q <= bus.i_roi_y1;
            margin_q <= bus.i_margin;
            acc_r_q  <= '0;  acc_g_q <= '0;  acc_b_q <= '0;
            cnt_q    <= '0;  x_q     <= '0;  y_q     <= '0;
            busy_q   <= 1'b1;
         end
         if (fetch && !fetch_last) addr_q <= addr_q + ADDR_W'(1);
         if (vld_w[RAM_LATENCY] && !odd_w[RAM_LATENCY]) hi_q <= bus.i_ram_data;
         if (vld_w[RAM_LATENCY] && odd_w[RAM_LATENCY]) begin
            if (in_roi) begin
               acc_r_q <= sat_add(acc_r_q, pix_r);
               acc_g_q <= sat_add(acc_g_q, pix_g);
               acc_b_q <= sat_add(acc_b_q, pix_b);
               if (cnt_q != {ADDR_W{1'b1}}) cnt_q <= cnt_q + ADDR_W'(1);
            end
            if (x_q == X_LAST) begin
               x_q <= '0;
               y_q <= y_q + CW'(1);
            end else begin
               x_q <= x_q + CW'(1);
            end
         end
         done_q <= decide;
         if (decide) begin
            color_q   <= color_d;
            sum_r_q   <= acc_r_q;  sum_g_q <= acc_g_q;  sum_b_q <= acc_b_q;
            cnt_pub_q <= cnt_q;
            busy_q    <= 1'b0;
            addr_q    <= '0;
         end
      end
   end

   assign bus.o_ram_addr  = addr_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_color     = color_q;
   assign bus.o_sum_r     = sum_r_q;
   assign bus.o_sum_g     = sum_g_q;
   assign bus.o_sum_b     = sum_b_q;
   assign bus.o_pix_count = cnt_pub_q;
endmodule

// File: tb/tb_color_classifier_roi.sv
// Runs two classifier variants (XRGB1555/4-wide/latency 1 and RGB565/160-wide/
// latency 3) from one shared frame RAM image against a behavioural model.
module tb_color_classifier_roi;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int max_addr_b = 0;
   logic [7:0] mem [0:255];

   color_classifier_roi_if #(.ADDR_W(15), .ACC_W(20)) ifa ();
   color_classifier_roi_if #(.ADDR_W(15), .ACC_W(20)) ifb ();

   color_classifier_roi #(.ADDR_W(15), .ACC_W(20), .IMG_W(4), .RAM_LATENCY(1), .FORMAT(0))
      dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
   color_classifier_roi #(.ADDR_W(15), .ACC_W(20), .IMG_W(160), .RAM_LATENCY(3), .FORMAT(1))
      dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

   logic [14:0] qa, qb0, qb1, qb2;
   always @(posedge clk) begin
      qa  <= ifa.o_ram_addr;
      qb0 <= ifb.o_ram_addr;
      qb1 <= qb0;
      qb2 <= qb1;
   end
   assign ifa.i_ram_data = mem[qa[7:0]];
   assign ifb.i_ram_data = mem[qb2[7:0]];

   typedef struct {
      int color; int sr; int sg; int sb; int cnt; int done_cyc;
   } exp_t;
   exp_t exp_a[$];
   exp_t exp_b[$];

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(int fmt, int imgw, int lat, int b, int x0, int x1,
                                  int y0, int y1, int margin, int s);
      exp_t e;
      int v[3];
      int bb, hi, lo, x, y, mx, idx, nmax;
      bit grey;
      bb = b - (b % 2);
      v = '{0, 0, 0};
      e.cnt = 0;
      for (int p = 0; p < bb / 2; p++) begin
         hi = int'(mem[2*p]);
         lo = int'(mem[2*p+1]);
         x = p % imgw;
         y = p / imgw;
         if (x >= x0 && x <= x1 && y >= y0 && y <= y1) begin
            if (fmt == 0) begin
               v[0] += (hi >> 2) & 31;
               v[1] += ((hi & 3) << 3) | (lo >> 5);
            end else begin
               v[0] += hi >> 3;
               v[1] += (((hi & 7) << 3) | (lo >> 5)) >> 1;
            end
            v[2] += lo & 31;
            e.cnt++;
         end
      end
      mx = v[0]; idx = 0;
      for (int j = 1; j < 3; j++) if (v[j] > mx) begin mx = v[j]; idx = j; end
      nmax = 0;
      for (int j = 0; j < 3; j++) if (v[j] == mx) nmax++;
      if (nmax > 1) e.color = 0;
      else begin
         grey = 1'b1;
         for (int j = 0; j < 3; j++) if (j != idx && !((mx - v[j]) < margin)) grey = 1'b0;
         e.color = grey ? 4 : idx + 1;
      end
      e.sr = v[0]; e.sg = v[1]; e.sb = v[2];
      e.done_cyc = s + bb + lat + 2;
      return e;
   endfunction

   task automatic compare_result(input string pfx, input exp_t e, input int col,
                                 input int sr, input int sg, input int sb, input int cnt,
                                 input int busy, input int addr);
      $display("txn %s cyc=%0d color=%02h r=%0d g=%0d b=%0d n=%0d", pfx, cyc, col, sr, sg, sb, cnt);
      check({pfx, "_color"}, col, e.color);
      check({pfx, "_sum_r"}, sr, e.sr);
      check({pfx, "_sum_g"}, sg, e.sg);
      check({pfx, "_sum_b"}, sb, e.sb);
      check({pfx, "_pix_count"}, cnt, e.cnt);
      check({pfx, "_done_cycle"}, cyc, e.done_cyc);
      check({pfx, "_busy_at_done"}, busy, 0);
      check({pfx, "_addr_at_done"}, addr, 0);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (int'(ifb.o_ram_addr) > max_addr_b) max_addr_b = int'(ifb.o_ram_addr);
         if (!rst && ifa.o_done) begin
            if (exp_a.size() == 0) check("a_unexpected_done", 1, 0);
            else begin
               e = exp_a.pop_front();
               compare_result("a", e, int'(ifa.o_color), int'(ifa.o_sum_r), int'(ifa.o_sum_g),
                              int'(ifa.o_sum_b), int'(ifa.o_pix_count), int'(ifa.o_busy),
                              int'(ifa.o_ram_addr));
            end
         end
         if (!rst && ifb.o_done) begin
            if (exp_b.size() == 0) check("b_unexpected_done", 1, 0);
            else begin
               e = exp_b.pop_front();
               compare_result("b", e, int'(ifb.o_color), int'(ifb.o_sum_r), int'(ifb.o_sum_g),
                              int'(ifb.o_sum_b), int'(ifb.o_pix_count), int'(ifb.o_busy),
                              int'(ifb.o_ram_addr));
            end
         end
      end
   endtask

   task automatic drive(input int b, input int x0, input int x1, input int y0, input int y1,
                        input int margin);
      ifa.i_bytes_per_frame = 15'(b);  ifb.i_bytes_per_frame = 15'(b);
      ifa.i_roi_x0 = 8'(x0);  ifb.i_roi_x0 = 8'(x0);
      ifa.i_roi_x1 = 8'(x1);  ifb.i_roi_x1 = 8'(x1);
      ifa.i_roi_y0 = 8'(y0);  ifb.i_roi_y0 = 8'(y0);
      ifa.i_roi_y1 = 8'(y1);  ifb.i_roi_y1 = 8'(y1);
      ifa.i_margin = 20'(margin);  ifb.i_margin = 20'(margin);
   endtask

   task automatic wait_empty();
      int n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("pending_results", exp_a.size() + exp_b.size(), 0);
      exp_a.delete();
      exp_b.delete();
   endtask

   // Launch a frame on both variants; returns the start cycle.
   task automatic launch(input int b, input int x0, input int x1, input int y0, input int y1,
                         input int margin, output int s);
      @(negedge clk);
      drive(b, x0, x1, y0, y1, margin);
      ifa.i_start = 1'b1;
      ifb.i_start = 1'b1;
      s = cyc;
      exp_a.push_back(model(0, 4, 1, b, x0, x1, y0, y1, margin, s));
      exp_b.push_back(model(1, 160, 3, b, x0, x1, y0, y1, margin, s));
      @(negedge clk);
      ifa.i_start = 1'b0;
      ifb.i_start = 1'b0;
   endtask

   task automatic run(input int b, input int x0, input int x1, input int y0, input int y1,
                      input int margin);
      int s;
      launch(b, x0, x1, y0, y1, margin, s);
      wait_empty();
   endtask

   task automatic set_pix(input int p, input logic [7:0] hi, input logic [7:0] lo);
      mem[2*p]   = hi;
      mem[2*p+1] = lo;
   endtask

   initial begin
      int s;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ifa.i_start = 1'b0;
      ifb.i_start = 1'b0;
      drive(0, 0, 255, 0, 255, 0);
      fork
         monitor();
      join_none

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("a_reset_color", int'(ifa.o_color), 8'hF0);
      check("b_reset_color", int'(ifb.o_color), 8'hF0);
      check("a_reset_busy", int'(ifa.o_busy), 0);
      check("a_reset_addr", int'(ifa.o_ram_addr), 0);
      check("a_reset_sum_r", int'(ifa.o_sum_r), 0);
      check("b_reset_pix_count", int'(ifb.o_pix_count), 0);

      for (int p = 0; p < 4; p++) set_pix(p, 8'h7C, 8'h00);
      run(8, 0, 255, 0, 255, 10);
      check("a_red_sum_r", int'(ifa.o_sum_r), 124);
      check("a_red_color", int'(ifa.o_color), 8'h01);
      check("a_red_count", int'(ifa.o_pix_count), 4);

      run(8, 0, 255, 0, 255, 200);
      check("a_grey_color", int'(ifa.o_color), 8'h04);

      run(8, 5, 2, 0, 255, 10);
      check("a_empty_roi_color", int'(ifa.o_color), 8'h00);
      check("a_empty_roi_sum_r", int'(ifa.o_sum_r), 0);

      for (int p = 0; p < 4; p++) set_pix(p, 8'h00, 8'h00);
      run(8, 0, 255, 0, 255, 10);
      check("a_tie_color", int'(ifa.o_color), 8'h00);

      run(0, 0, 255, 0, 255, 10);

      for (int p = 0; p < 16; p++)
         if (p == 5 || p == 6) set_pix(p, 8'h00, 8'h1F);
         else                  set_pix(p, 8'h7C, 8'h00);
      run(32, 1, 2, 1, 1, 10);
      check("a_roi_sum_b", int'(ifa.o_sum_b), 62);
      check("a_roi_sum_r", int'(ifa.o_sum_r), 0);
      check("a_roi_count", int'(ifa.o_pix_count), 2);
      check("a_roi_color", int'(ifa.o_color), 8'h03);

      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      set_pix(0, 8'h07, 8'hE0);
      set_pix(1, 8'h07, 8'hE0);
      mem[4] = 8'hFF;
      mem[5] = 8'hFF;
      max_addr_b = 0;
      run(5, 0, 255, 0, 255, 10);
      check("b_g6_sum_g", int'(ifb.o_sum_g), 62);
      check("b_g6_color", int'(ifb.o_color), 8'h02);
      check("b_odd_max_addr", max_addr_b, 3);

      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
      @(negedge clk);
      drive(40, 0, 255, 0, 255, 30);
      ifa.i_start = 1'b1;
      ifb.i_start = 1'b1;
      @(negedge clk);
      ifa.i_start = 1'b0;
      ifb.i_start = 1'b0;
      repeat (4) @(negedge clk);
      check("b_busy_midframe", int'(ifb.o_busy), 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("a_abort_color", int'(ifa.o_color), 8'hF0);
      check("b_abort_color", int'(ifb.o_color), 8'hF0);
      check("b_abort_busy", int'(ifb.o_busy), 0);
      check("b_abort_addr", int'(ifb.o_ram_addr), 0);
      check("b_abort_sum_g", int'(ifb.o_sum_g), 0);
      repeat (60) @(negedge clk);
      run(40, 0, 255, 0, 255, 30);

      launch(16, 1, 3, 0, 255, 10, s);
      repeat (3) @(negedge clk);
      drive(8, 0, 0, 0, 0, 500);
      ifa.i_start = 1'b1;
      ifb.i_start = 1'b1;
      @(negedge clk);
      ifa.i_start = 1'b0;
      ifb.i_start = 1'b0;
      wait_empty();
      repeat (30) @(negedge clk);

      launch(8, 0, 255, 0, 255, 10, s);
      while (cyc < s + 11) @(negedge clk);
      ifa.i_start = 1'b1;
      @(negedge clk);
      ifa.i_start = 1'b0;
      check("a_start_at_done_busy", int'(ifa.o_busy), 0);
      wait_empty();
      repeat (30) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
